toggle_reg_arbiter: RTL and testbench

//  Shares one WIDTH-bit toggle register (a bank of T flip-flops, q <= q ^ t) between N_REQ requesters.

---
 rtl/toggle_reg_arbiter.sv | 110 +++++++++++
 tb/tb_toggle_reg_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_reg_arbiter.sv
// Round-robin arbiter that shares one T-flop register among N_REQ requesters.
// Each granted toggle mask is applied to q as one atomic update, and an ack pulse follows.
module toggle_reg_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] tmask,
   input  logic                   clr,
   output logic [N_REQ-1:0]       gnt,
   output logic                   ack,
   output logic [WIDTH-1:0]       q,
   output logic [WIDTH-1:0]       qn,
   output logic                   busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Handshake: a requester raises req[i] with a stable tmask slice and holds both
   // until it sees ack; the mask is captured on the grant edge only.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      APPLY = 2'd2
   } state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [WIDTH-1:0] mask_r;

   logic [PW-1:0]   scan_win;
   logic [PW-1:0]   scan_cand;
   logic            scan_any;
   logic [PW-1:0]   ptr_next;

   // The first set req bit at or after ptr (wrapping) wins.
   always_comb begin
      scan_win  = ptr;
      scan_cand = ptr;
      scan_any  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_cand = PW'((int'(ptr) + i) % N_REQ);
         if (!scan_any && req[scan_cand]) begin
            scan_any = 1'b1;
            scan_win = scan_cand;
         end
      end
   end

   assign ptr_next = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         q      <= '0;
         gnt    <= '0;
         ack    <= 1'b0;
         ptr    <= '0;
         win    <= '0;
         mask_r <= '0;
      end else begin
         // clr wins over a toggle on the same edge; the sequencer still completes.
         if (clr)
            q <= '0;
         else if (state == GRANT && req[win])
            q <= q ^ mask_r;

         case (state)
            IDLE: begin
               ack <= 1'b0;
               if (scan_any) begin
                  state  <= GRANT;
                  gnt    <= N_REQ'(1) << scan_win;
                  win    <= scan_win;
                  mask_r <= tmask[int'(scan_win)*WIDTH +: WIDTH];
               end else begin
                  gnt <= '0;
               end
            end
            GRANT: begin
               if (req[win]) begin
                  state <= APPLY;
                  ack   <= 1'b1;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
               end
            end
            APPLY: begin
               state <= IDLE;
               ack   <= 1'b0;
               gnt   <= '0;
               ptr   <= ptr_next;
            end
            default: begin
               state <= IDLE;
               ack   <= 1'b0;
               gnt   <= '0;
            end
         endcase
      end
   end

   assign qn   = ~q;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_toggle_reg_arbiter.sv
// Directed self-checking bench for toggle_reg_arbiter (N_REQ=4, WIDTH=8).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_toggle_reg_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] tmask;
   logic        clr;
   logic [3:0]  gnt;
   logic        ack;
   logic [7:0]  q;
   logic [7:0]  qn;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   toggle_reg_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .tmask (tmask),
      .clr   (clr),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .qn    (qn),
      .busy  (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_mask(input int i, input logic [7:0] m);
      tmask[i*8 +: 8] = m;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '0;
      tmask = '0;
      clr   = 1'b0;
      #3;
      n_checks++; if (q !== 8'h00)  begin n_fail++; $display("FAIL reset_q: got %h expected 00", q); end
      n_checks++; if (qn !== 8'hFF) begin n_fail++; $display("FAIL reset_qn: got %h expected FF", qn); end
      n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_round_robin();
      logic [7:0] q_exp;
      logic [3:0] g_exp;
      set_mask(0, 8'h01);
      set_mask(1, 8'h02);
      set_mask(2, 8'h04);
      set_mask(3, 8'h08);
      q_exp = 8'h00;
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         g_exp = 4'b0001 << (g % 4);
         tick();
         n_checks++; if (gnt !== g_exp) begin n_fail++; $display("FAIL rr_gnt%0d: got %b expected %b", g, gnt, g_exp); end
         n_checks++; if (busy !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL rr_grant_state%0d: got busy=%b ack=%b expected busy=1 ack=0", g, busy, ack); end
         tick();
         q_exp = q_exp ^ g_exp[3:0];
         n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rr_ack%0d: got %b expected 1", g, ack); end
         n_checks++; if (q !== q_exp) begin n_fail++; $display("FAIL rr_q%0d: got %h expected %h", g, q, q_exp); end
         if (g == 3) begin
            n_checks++; if (q !== 8'h0F) begin n_fail++; $display("FAIL rr_q_after4: got %h expected 0F", q); end
         end
         if (g == 4) req = 4'b0000;
         tick();
         n_checks++; if (ack !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d: got ack=%b gnt=%b busy=%b expected 0 0000 0", g, ack, gnt, busy); end
      end
   endtask

   task automatic test_clear_idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_checks++; if (q !== 8'h00 || qn !== 8'hFF) begin n_fail++; $display("FAIL clr_idle: got q=%h qn=%h expected 00 FF", q, qn); end
      n_checks++; if (ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle_fsm: got ack=%b busy=%b expected 0 0", ack, busy); end
   endtask

   task automatic test_single();
      set_mask(1, 8'hA5);
      req = 4'b0010;
      tick();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt: got %b expected 0010", gnt); end
      n_checks++; if (q !== 8'h00 || ack !== 1'b0) begin n_fail++; $display("FAIL single_early: got q=%h ack=%b expected 00 0", q, ack); end
      // mask change after capture must not affect this transaction
      set_mask(1, 8'h0F);
      tick();
      n_checks++; if (q !== 8'hA5 || qn !== 8'h5A) begin n_fail++; $display("FAIL single_q: got q=%h qn=%h expected A5 5A", q, qn); end
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b expected 1", ack); end
      req = 4'b0000;
      set_mask(1, 8'hA5);
      tick();
      n_checks++; if (ack !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0) begin n_fail++; $display("FAIL single_idle: got ack=%b busy=%b gnt=%b expected 0 0 0000", ack, busy, gnt); end
      req = 4'b0010;
      tick();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single2_gnt: got %b expected 0010", gnt); end
      tick();
      n_checks++; if (q !== 8'h00 || ack !== 1'b1) begin n_fail++; $display("FAIL single2_q: got q=%h ack=%b expected 00 1", q, ack); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_wrap();
      // zero mask from requester 2 moves the pointer to 3
      set_mask(2, 8'h00);
      req = 4'b0100;
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL zero_mask_gnt: got %b expected 0100", gnt); end
      tick();
      n_checks++; if (ack !== 1'b1 || q !== 8'h00) begin n_fail++; $display("FAIL zero_mask_ack: got ack=%b q=%h expected 1 00", ack, q); end
      req = 4'b0000;
      tick();
      set_mask(3, 8'h30);
      set_mask(0, 8'h03);
      req = 4'b1001;
      tick();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt3: got %b expected 1000", gnt); end
      tick();
      n_checks++; if (q !== 8'h30 || ack !== 1'b1) begin n_fail++; $display("FAIL wrap_q3: got q=%h ack=%b expected 30 1", q, ack); end
      req = 4'b0001;
      tick();
      n_checks++; if (gnt !== 4'b0 || ack !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got gnt=%b ack=%b expected 0000 0", gnt, ack); end
      tick();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt0: got %b expected 0001", gnt); end
      tick();
      n_checks++; if (q !== 8'h33 || ack !== 1'b1) begin n_fail++; $display("FAIL wrap_q0: got q=%h ack=%b expected 33 1", q, ack); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_abort();
      set_mask(2, 8'hC0);
      req = 4'b0100;
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_gnt: got %b expected 0100", gnt); end
      req = 4'b0000;
      tick();
      n_checks++; if (gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got gnt=%b ack=%b busy=%b expected 0000 0 0", gnt, ack, busy); end
      n_checks++; if (q !== 8'h33) begin n_fail++; $display("FAIL abort_q: got %h expected 33", q); end
      tick();
      n_checks++; if (ack !== 1'b0 || q !== 8'h33) begin n_fail++; $display("FAIL abort_late: got ack=%b q=%h expected 0 33", ack, q); end
      // pointer still 1: scan 1,2 picks 2 (an advanced pointer of 3 would pick 0)
      set_mask(0, 8'h01);
      set_mask(2, 8'h0C);
      req = 4'b0101;
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_ptr_gnt: got %b expected 0100", gnt); end
      tick();
      n_checks++; if (q !== 8'h3F || ack !== 1'b1) begin n_fail++; $display("FAIL abort_ptr_q: got q=%h ack=%b expected 3F 1", q, ack); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_clear_collision();
      set_mask(3, 8'h03);
      req = 4'b1000;
      tick();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL cc_setup_gnt: got %b expected 1000", gnt); end
      tick();
      n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL cc_setup_q: got %h expected 3C", q); end
      req = 4'b0000;
      tick();
      set_mask(0, 8'hFF);
      req = 4'b0001;
      tick();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL cc_gnt: got %b expected 0001", gnt); end
      clr = 1'b1;
      tick();
      n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL cc_q: got %h expected 00", q); end
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL cc_ack: got %b expected 1", ack); end
      clr = 1'b0;
      req = 4'b0000;
      tick();
      n_checks++; if (ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cc_idle: got ack=%b busy=%b expected 0 0", ack, busy); end
      // pointer advanced to 1: requester 1 beats requester 0
      set_mask(0, 8'h01);
      set_mask(1, 8'h02);
      req = 4'b0011;
      tick();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL cc_ptr_gnt: got %b expected 0010", gnt); end
      tick();
      n_checks++; if (q !== 8'h02 || ack !== 1'b1) begin n_fail++; $display("FAIL cc_ptr_q: got q=%h ack=%b expected 02 1", q, ack); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid();
      set_mask(2, 8'h50);
      req = 4'b0100;
      tick();
      n_checks++; if (gnt !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got gnt=%b busy=%b expected 0100 1", gnt, busy); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (q !== 8'h00 || qn !== 8'hFF) begin n_fail++; $display("FAIL rmid_q: got q=%h qn=%h expected 00 FF", q, qn); end
      n_checks++; if (gnt !== 4'b0 || ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_fsm: got gnt=%b ack=%b busy=%b expected 0000 0 0", gnt, ack, busy); end
      req = 4'b0000;
      tick();
      n_checks++; if (q !== 8'h00 || ack !== 1'b0) begin n_fail++; $display("FAIL rmid_hold: got q=%h ack=%b expected 00 0", q, ack); end
      rst_n = 1'b1;
      tick();
      // pointer back at 0 after reset
      req = 4'b1111;
      tick();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr: got %b expected 0001", gnt); end
      req = 4'b0000;
      tick();
      n_checks++; if (gnt !== 4'b0 || ack !== 1'b0 || q !== 8'h00) begin n_fail++; $display("FAIL rmid_abort: got gnt=%b ack=%b q=%h expected 0000 0 00", gnt, ack, q); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_clear_idle();
      test_single();
      test_wrap();
      test_abort();
      test_clear_collision();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
